// File: rtl/reg_read_multi.sv
`default_nettype none
// ============================================================================
//  Module      : reg_read_multi
//  Description : Multi-lane register-read stage sitting between the scheduler
//                and the execute units. Each cycle a bundle of NUM_LANES
//                instructions may be accepted. Operands are resolved at
//                capture: physical register 0 reads as zero, otherwise the
//                lowest-index matching writeback bypass wins over the
//                register file value. Two bundle slots are held:
//                  OUT  - drives exec_* directly
//                  SKID - catches one bundle while OUT is stalled
//                Held operands keep snooping the bypass buses every cycle,
//                so a stalled instruction never goes stale.
//
//  Ports       : clk, rst (async, active-low)       clock / reset
//                flush                              drop OUT and SKID
//                sched_*                            scheduler bundle in
//                sched_ready                        bundle can be accepted
//                rf_src*_reg / rf_src*_val          register file read port
//                byp_valid / byp_preg / byp_val     writeback bypass buses
//                exec_*                             bundle to execute
//
//  Revision    : 1.0  initial release
// ============================================================================
module reg_read_multi #(
    parameter int  NUM_LANES  = 2,
    parameter int  NUM_BYPASS = 2,
    parameter int  NUM_PREGS  = 64,
    parameter int  DATA_W     = 32,
    localparam int PREG_W     = $clog2(NUM_PREGS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    // scheduler side
    input  logic [NUM_LANES-1:0]          sched_fire_valid,
    output logic                          sched_ready,
    input  logic [NUM_LANES*DATA_W-1:0]   sched_pc,
    input  logic [NUM_LANES*DATA_W-1:0]   sched_imm_val,
    input  logic [NUM_LANES*PREG_W-1:0]   sched_src1_preg,
    input  logic [NUM_LANES*PREG_W-1:0]   sched_src2_preg,
    input  logic [NUM_LANES*PREG_W-1:0]   sched_dst_preg,
    // register file read port
    output logic [NUM_LANES*PREG_W-1:0]   rf_src1_reg,
    output logic [NUM_LANES*PREG_W-1:0]   rf_src2_reg,
    input  logic [NUM_LANES*DATA_W-1:0]   rf_src1_val,
    input  logic [NUM_LANES*DATA_W-1:0]   rf_src2_val,
    // writeback bypass buses
    input  logic [NUM_BYPASS-1:0]         byp_valid,
    input  logic [NUM_BYPASS*PREG_W-1:0]  byp_preg,
    input  logic [NUM_BYPASS*DATA_W-1:0]  byp_val,
    // execute side
    output logic [NUM_LANES-1:0]          exec_fire_valid,
    input  logic                          exec_ready,
    output logic [NUM_LANES*DATA_W-1:0]   exec_pc,
    output logic [NUM_LANES*DATA_W-1:0]   exec_imm_val,
    output logic [NUM_LANES*DATA_W-1:0]   exec_src1_val,
    output logic [NUM_LANES*DATA_W-1:0]   exec_src2_val,
    output logic [NUM_LANES*PREG_W-1:0]   exec_src1_preg,
    output logic [NUM_LANES*PREG_W-1:0]   exec_src2_preg,
    output logic [NUM_LANES*PREG_W-1:0]   exec_dst_preg
);

    localparam int LD_W = NUM_LANES * DATA_W;
    localparam int LP_W = NUM_LANES * PREG_W;

    // ------------------------------------------------------------------
    // Bundle storage
    // ------------------------------------------------------------------
    logic              r_alive;       // low during reset, high from first edge after
    logic [NUM_LANES-1:0] r_out_valid;
    logic [LD_W-1:0]   r_out_pc, r_out_imm, r_out_s1v, r_out_s2v;
    logic [LP_W-1:0]   r_out_s1p, r_out_s2p, r_out_dp;
    logic [NUM_LANES-1:0] r_skid_valid;
    logic [LD_W-1:0]   r_skid_pc, r_skid_imm, r_skid_s1v, r_skid_s2v;
    logic [LP_W-1:0]   r_skid_s1p, r_skid_s2p, r_skid_dp;

    // Next-state values
    logic [NUM_LANES-1:0] w_nxt_out_valid;
    logic [LD_W-1:0]   w_nxt_out_pc, w_nxt_out_imm, w_nxt_out_s1v, w_nxt_out_s2v;
    logic [LP_W-1:0]   w_nxt_out_s1p, w_nxt_out_s2p, w_nxt_out_dp;
    logic [NUM_LANES-1:0] w_nxt_skid_valid;
    logic [LD_W-1:0]   w_nxt_skid_pc, w_nxt_skid_imm, w_nxt_skid_s1v, w_nxt_skid_s2v;
    logic [LP_W-1:0]   w_nxt_skid_s1p, w_nxt_skid_s2p, w_nxt_skid_dp;

    // Incoming bundle after operand resolution
    logic [NUM_LANES-1:0] w_new_valid;
    logic [LD_W-1:0]   w_new_pc, w_new_imm, w_new_s1v, w_new_s2v;
    logic [LP_W-1:0]   w_new_s1p, w_new_s2p, w_new_dp;

    // Held operand values after this cycle's bypass snoop
    logic [LD_W-1:0]   w_out_s1v_snp, w_out_s2v_snp;
    logic [LD_W-1:0]   w_skid_s1v_snp, w_skid_s2v_snp;

    logic w_out_occ;
    logic w_skid_occ;
    logic w_accept;
    logic w_out_adv;

    // Lowest-index valid bypass whose preg matches wins; dflt otherwise.
    // Scanning high-to-low lets the lowest index overwrite last.
    function automatic logic [DATA_W-1:0] f_bypass(
        input logic [PREG_W-1:0] preg,
        input logic [DATA_W-1:0] dflt
    );
        logic [DATA_W-1:0] v;
        v = dflt;
        for (int k = NUM_BYPASS - 1; k >= 0; k--) begin
            if (byp_valid[k] && (byp_preg[k*PREG_W +: PREG_W] == preg)) begin
                v = byp_val[k*DATA_W +: DATA_W];
            end
        end
        return v;
    endfunction

    // Capture-time operand: preg 0 is the hardwired zero register.
    function automatic logic [DATA_W-1:0] f_operand(
        input logic [PREG_W-1:0] preg,
        input logic [DATA_W-1:0] rf_val
    );
        if (preg == '0) begin
            return '0;
        end
        return f_bypass(preg, rf_val);
    endfunction

    // Held snoop: only valid lanes with a real (nonzero) source update.
    function automatic logic [DATA_W-1:0] f_snoop(
        input logic              valid,
        input logic [PREG_W-1:0] preg,
        input logic [DATA_W-1:0] held
    );
        if (!valid || (preg == '0)) begin
            return held;
        end
        return f_bypass(preg, held);
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_out_occ   = |r_out_valid;
    assign w_skid_occ  = |r_skid_valid;
    // Purely registered: no path from exec_ready.
    assign sched_ready = r_alive && !w_skid_occ;
    assign w_accept    = sched_ready && (|sched_fire_valid);
    assign w_out_adv   = exec_ready || !w_out_occ;

    assign rf_src1_reg = sched_src1_preg;
    assign rf_src2_reg = sched_src2_preg;

    // ------------------------------------------------------------------
    // Incoming bundle; invalid lanes are zeroed so no stray data is held
    // ------------------------------------------------------------------
    always_comb begin
        w_new_valid = '0;
        w_new_pc    = '0;
        w_new_imm   = '0;
        w_new_s1p   = '0;
        w_new_s2p   = '0;
        w_new_dp    = '0;
        w_new_s1v   = '0;
        w_new_s2v   = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (sched_fire_valid[l]) begin
                w_new_valid[l]                 = 1'b1;
                w_new_pc[l*DATA_W +: DATA_W]   = sched_pc[l*DATA_W +: DATA_W];
                w_new_imm[l*DATA_W +: DATA_W]  = sched_imm_val[l*DATA_W +: DATA_W];
                w_new_s1p[l*PREG_W +: PREG_W]  = sched_src1_preg[l*PREG_W +: PREG_W];
                w_new_s2p[l*PREG_W +: PREG_W]  = sched_src2_preg[l*PREG_W +: PREG_W];
                w_new_dp[l*PREG_W +: PREG_W]   = sched_dst_preg[l*PREG_W +: PREG_W];
                w_new_s1v[l*DATA_W +: DATA_W]  = f_operand(sched_src1_preg[l*PREG_W +: PREG_W],
                                                           rf_src1_val[l*DATA_W +: DATA_W]);
                w_new_s2v[l*DATA_W +: DATA_W]  = f_operand(sched_src2_preg[l*PREG_W +: PREG_W],
                                                           rf_src2_val[l*DATA_W +: DATA_W]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Bypass snoop on held bundles
    // ------------------------------------------------------------------
    always_comb begin
        w_out_s1v_snp  = r_out_s1v;
        w_out_s2v_snp  = r_out_s2v;
        w_skid_s1v_snp = r_skid_s1v;
        w_skid_s2v_snp = r_skid_s2v;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_out_s1v_snp[l*DATA_W +: DATA_W]  = f_snoop(r_out_valid[l],
                r_out_s1p[l*PREG_W +: PREG_W], r_out_s1v[l*DATA_W +: DATA_W]);
            w_out_s2v_snp[l*DATA_W +: DATA_W]  = f_snoop(r_out_valid[l],
                r_out_s2p[l*PREG_W +: PREG_W], r_out_s2v[l*DATA_W +: DATA_W]);
            w_skid_s1v_snp[l*DATA_W +: DATA_W] = f_snoop(r_skid_valid[l],
                r_skid_s1p[l*PREG_W +: PREG_W], r_skid_s1v[l*DATA_W +: DATA_W]);
            w_skid_s2v_snp[l*DATA_W +: DATA_W] = f_snoop(r_skid_valid[l],
                r_skid_s2p[l*PREG_W +: PREG_W], r_skid_s2v[l*DATA_W +: DATA_W]);
        end
    end

    // ------------------------------------------------------------------
    // Slot movement. SKID is always older than any accepted bundle, so
    // it moves to OUT first; a bundle accepted that same cycle lands in
    // SKID. sched_ready is low whenever SKID is occupied, so SKID never
    // has to hold its contents and take a new bundle at once.
    // ------------------------------------------------------------------
    always_comb begin
        w_nxt_out_valid  = r_out_valid;
        w_nxt_out_pc     = r_out_pc;
        w_nxt_out_imm    = r_out_imm;
        w_nxt_out_s1p    = r_out_s1p;
        w_nxt_out_s2p    = r_out_s2p;
        w_nxt_out_dp     = r_out_dp;
        w_nxt_out_s1v    = w_out_s1v_snp;
        w_nxt_out_s2v    = w_out_s2v_snp;
        w_nxt_skid_valid = r_skid_valid;
        w_nxt_skid_pc    = r_skid_pc;
        w_nxt_skid_imm   = r_skid_imm;
        w_nxt_skid_s1p   = r_skid_s1p;
        w_nxt_skid_s2p   = r_skid_s2p;
        w_nxt_skid_dp    = r_skid_dp;
        w_nxt_skid_s1v   = w_skid_s1v_snp;
        w_nxt_skid_s2v   = w_skid_s2v_snp;

        if (flush) begin
            w_nxt_out_valid  = '0;
            w_nxt_skid_valid = '0;
        end else if (w_out_adv) begin
            if (w_skid_occ) begin
                w_nxt_out_valid = r_skid_valid;
                w_nxt_out_pc    = r_skid_pc;
                w_nxt_out_imm   = r_skid_imm;
                w_nxt_out_s1p   = r_skid_s1p;
                w_nxt_out_s2p   = r_skid_s2p;
                w_nxt_out_dp    = r_skid_dp;
                w_nxt_out_s1v   = w_skid_s1v_snp;
                w_nxt_out_s2v   = w_skid_s2v_snp;
                if (w_accept) begin
                    w_nxt_skid_valid = w_new_valid;
                    w_nxt_skid_pc    = w_new_pc;
                    w_nxt_skid_imm   = w_new_imm;
                    w_nxt_skid_s1p   = w_new_s1p;
                    w_nxt_skid_s2p   = w_new_s2p;
                    w_nxt_skid_dp    = w_new_dp;
                    w_nxt_skid_s1v   = w_new_s1v;
                    w_nxt_skid_s2v   = w_new_s2v;
                end else begin
                    w_nxt_skid_valid = '0;
                end
            end else if (w_accept) begin
                w_nxt_out_valid = w_new_valid;
                w_nxt_out_pc    = w_new_pc;
                w_nxt_out_imm   = w_new_imm;
                w_nxt_out_s1p   = w_new_s1p;
                w_nxt_out_s2p   = w_new_s2p;
                w_nxt_out_dp    = w_new_dp;
                w_nxt_out_s1v   = w_new_s1v;
                w_nxt_out_s2v   = w_new_s2v;
            end else begin
                w_nxt_out_valid = '0;
            end
        end else if (w_accept) begin
            // OUT stalled: SKID is empty here because sched_ready was high.
            w_nxt_skid_valid = w_new_valid;
            w_nxt_skid_pc    = w_new_pc;
            w_nxt_skid_imm   = w_new_imm;
            w_nxt_skid_s1p   = w_new_s1p;
            w_nxt_skid_s2p   = w_new_s2p;
            w_nxt_skid_dp    = w_new_dp;
            w_nxt_skid_s1v   = w_new_s1v;
            w_nxt_skid_s2v   = w_new_s2v;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alive      <= 1'b0;
            r_out_valid  <= '0;
            r_out_pc     <= '0;
            r_out_imm    <= '0;
            r_out_s1p    <= '0;
            r_out_s2p    <= '0;
            r_out_dp     <= '0;
            r_out_s1v    <= '0;
            r_out_s2v    <= '0;
            r_skid_valid <= '0;
            r_skid_pc    <= '0;
            r_skid_imm   <= '0;
            r_skid_s1p   <= '0;
            r_skid_s2p   <= '0;
            r_skid_dp    <= '0;
            r_skid_s1v   <= '0;
            r_skid_s2v   <= '0;
        end else begin
            r_alive      <= 1'b1;
            r_out_valid  <= w_nxt_out_valid;
            r_out_pc     <= w_nxt_out_pc;
            r_out_imm    <= w_nxt_out_imm;
            r_out_s1p    <= w_nxt_out_s1p;
            r_out_s2p    <= w_nxt_out_s2p;
            r_out_dp     <= w_nxt_out_dp;
            r_out_s1v    <= w_nxt_out_s1v;
            r_out_s2v    <= w_nxt_out_s2v;
            r_skid_valid <= w_nxt_skid_valid;
            r_skid_pc    <= w_nxt_skid_pc;
            r_skid_imm   <= w_nxt_skid_imm;
            r_skid_s1p   <= w_nxt_skid_s1p;
            r_skid_s2p   <= w_nxt_skid_s2p;
            r_skid_dp    <= w_nxt_skid_dp;
            r_skid_s1v   <= w_nxt_skid_s1v;
            r_skid_s2v   <= w_nxt_skid_s2v;
        end
    end

    // ------------------------------------------------------------------
    // Execute outputs come straight from OUT
    // ------------------------------------------------------------------
    assign exec_fire_valid = r_out_valid;
    assign exec_pc         = r_out_pc;
    assign exec_imm_val    = r_out_imm;
    assign exec_src1_val   = r_out_s1v;
    assign exec_src2_val   = r_out_s2v;
    assign exec_src1_preg  = r_out_s1p;
    assign exec_src2_preg  = r_out_s2p;
    assign exec_dst_preg   = r_out_dp;

endmodule
`default_nettype wire

// File: doc/reg_read_multi.md
REG_READ_MULTI -- requirements
Module: reg_read_multi

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 2, meaning number of issue lanes read per cycle.
REQ-002 The block SHALL have parameter NUM_BYPASS, default 2, meaning number of writeback bypass buses snooped.
REQ-003 The block SHALL have parameter NUM_PREGS, default 64, meaning physical register count; PREG_W = $clog2(NUM_PREGS).
REQ-004 The block SHALL have parameter DATA_W, default 32, meaning operand/PC/immediate width.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low (ports clk, rst; rst asserted low).
REQ-006 Ports SHALL be: clk  in  1  clock.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 flush  in  1  discard all held instructions.
REQ-009 sched_fire_valid  in  NUM_LANES  per-lane instruction valid.
REQ-010 sched_ready  out  1  block accepts a lane bundle this cycle.
REQ-011 sched_pc, sched_imm_val  in  NUM_LANES*DATA_W  per-lane PC, immediate.
REQ-012 sched_src1_preg, sched_src2_preg, sched_dst_preg  in  NUM_LANES*PREG_W  per-lane registers.
REQ-013 rf_src1_reg, rf_src2_reg  out  NUM_LANES*PREG_W  register file read addresses (combinational from sched_*).
REQ-014 rf_src1_val, rf_src2_val  in  NUM_LANES*DATA_W  register file data, same cycle.
REQ-015 byp_valid  in  NUM_BYPASS; byp_preg  in  NUM_BYPASS*PREG_W; byp_val  in  NUM_BYPASS*DATA_W  bypass buses.
REQ-016 exec_fire_valid  out  NUM_LANES; exec_ready  in  1  execute handshake.
REQ-017 exec_pc, exec_imm_val, exec_src1_val, exec_src2_val  out  NUM_LANES*DATA_W; exec_src1_preg, exec_src2_preg, exec_dst_preg  out  NUM_LANES*PREG_W.

Function
REQ-018 Storage SHALL be one output bundle register (OUT) plus one skid bundle register (SKID), each with per-lane valid bits; bundle occupied = any lane valid.
REQ-019 sched_ready SHALL equal !SKID occupied (registered state, no combinational path from exec_ready).
REQ-020 Accept SHALL occur when sched_ready and any sched_fire_valid bit set; lanes with fire_valid=0 are captured invalid.
REQ-021 Operand selection at capture, per lane/source: preg==0 -> 0; else lowest-index bypass k with byp_valid[k] and byp_preg[k]==preg -> byp_val[k]; else rf value.
REQ-022 Latency SHALL be one cycle: bundle accepted at edge N appears on exec_* after edge N when OUT is free or draining.
REQ-023 OUT advances when exec_ready=1 or OUT unoccupied: loads SKID if occupied, else accepted bundle, else clears valids.
REQ-024 If OUT occupied, exec_ready=0 and accept occurs, bundle SHALL go to SKID; SKID and OUT both full -> sched_ready=0 next cycle.
REQ-025 Simultaneous SKID->OUT move and accept SHALL place new bundle in SKID; ordering SHALL be preserved, never reordered or dropped.
REQ-026 Snooping: every cycle, each valid held lane source (OUT and SKID) with nonzero preg matching a valid bypass SHALL replace its value with lowest-index matching byp_val.
REQ-027 exec_* SHALL be driven directly from OUT; exec_fire_valid = OUT lane valids.
REQ-028 flush SHALL clear all OUT and SKID valids at the next edge, overriding accept and moves; sched_ready=1 the following cycle.
REQ-029 Data fields of invalid lanes are don't-care but SHALL not produce X on outputs after reset.

Reset
REQ-030 While rst=0, all valids, data fields and exec_* outputs SHALL be 0 and sched_ready SHALL be 0; sched_ready=1 in the first cycle after release.
REQ-031 Reset asserted mid-stall SHALL discard OUT and SKID contents immediately, asynchronously.

Verification
REQ-032 Lane0 src1=5,src2=10, rf=AAAA_AAAA/BBBB_BBBB, no bypass, exec_ready=1 -> next cycle exec_fire_valid[0]=1, vals AAAA_AAAA/BBBB_BBBB.
REQ-033 Lane1 src1=7 with byp0 and byp1 both preg 7 (DEAD_BEEF/CAFE_BABE) -> exec_src1_val[1]=DEAD_BEEF; src=0 with bypass preg 0 -> value 0.
REQ-034 exec_ready=0, three bundles PC 0x1000/0x1004/0x1008 offered back-to-back -> sched_ready drops after second; on release PCs exit 0x1000,0x1004,0x1008 in order.
REQ-035 OUT held (src2=12, value 0x4444_4444), byp0 preg 12=0x9ABC_DEF0 during stall -> exec_src2_val becomes 0x9ABC_DEF0 before exec_ready.
REQ-036 OUT and SKID full, flush=1 -> next cycle exec_fire_valid=0, sched_ready=1; rst low mid-stall -> all outputs 0 immediately.
